// File: rtl/mux4_rr_feeder_pkg.sv
// ---------------------------------------------------------------------------
// mux4_pkg
// Shared constants and types for the mux4_rr_feeder slice: channel count,
// channel-index type, output-slot state and grant-counter width.
// ---------------------------------------------------------------------------
package mux4_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 16;

    typedef logic [SEL_W-1:0] sel_t;

    // Output slot occupancy: EMPTY -> out_valid=0, FULL -> out_valid=1.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mux4_rr_feeder_if.sv
// ---------------------------------------------------------------------------
// mux4_rr_feeder_if
// Bundles the four request/data channels and the downstream valid/ready
// handshake of mux4_rr_feeder.
//   master : feeder side (drives gnt, out_data, sel, out_valid)
//   slave  : environment side (drives req, a..d, out_ready)
// ---------------------------------------------------------------------------
interface mux4_rr_feeder_if #(
    parameter int WIDTH = 4
);
    import mux4_pkg::*;

    logic [N_CH-1:0]  req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [N_CH-1:0]  gnt;
    logic [WIDTH-1:0] out_data;
    sel_t             sel;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  req, a, b, c, d, out_ready,
        output gnt, out_data, sel, out_valid
    );

    modport slave (
        output req, a, b, c, d, out_ready,
        input  gnt, out_data, sel, out_valid
    );

endinterface

// File: rtl/mux4_rr_feeder_rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational rotate-priority picker. The search starts at last_ptr+1
// (mod 4) and wraps; the first set request bit wins.
//   req[3:0]      : request vector
//   last_ptr[1:0] : index of the previous winner
//   any           : at least one request set
//   idx[1:0]      : winning index (0 when no request)
//   onehot[3:0]   : one-hot of idx, all-zero when no request
// ---------------------------------------------------------------------------
module rr_pick4
    import mux4_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  sel_t            last_ptr,
    output logic            any,
    output sel_t            idx,
    output logic [N_CH-1:0] onehot
);

    sel_t w_cand;
    logic w_found;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        any     = |req;
        idx     = '0;
        onehot  = '0;
        w_cand  = '0;
        w_found = 1'b0;
        // Offset N_CH wraps back to last_ptr itself, so it is tried last.
        for (int i = 1; i <= N_CH; i++) begin
            w_cand = last_ptr + sel_t'(i);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                idx     = w_cand;
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mux4_rr_feeder.sv
// ---------------------------------------------------------------------------
// mux4_rr_feeder
// Upstream stage of the 4:1 mux datapath. Arbitrates channels a..d
// round-robin, registers the winning word together with its channel index,
// and offers it downstream through valid/ready at one word per cycle.
//   clk      : rising-edge clock
//   rstn     : asynchronous active-low reset
//   bus      : mux4_rr_feeder_if.master (req, a..d, gnt, out_data, sel,
//              out_valid, out_ready)
// Optional (macro MUX4_RR_GNT_CNT_EN):
//   cnt_clr  : synchronous clear of all grant counters (wins over increment)
//   gnt_cnt  : four saturating 16-bit grant counters, channel i at
//              bits [16*i+15:16*i]
// ---------------------------------------------------------------------------
module mux4_rr_feeder
    import mux4_pkg::*;
#(
    parameter int   WIDTH   = 4,
    parameter sel_t PTR_RST = 2'b11
)(
    input  logic                   clk,
    input  logic                   rstn,
`ifdef MUX4_RR_GNT_CNT_EN
    input  logic                   cnt_clr,
    output logic [N_CH*CNT_W-1:0]  gnt_cnt,
`endif
    mux4_rr_feeder_if.master       bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    sel_t             r_sel;
    sel_t             r_ptr;

    logic             w_any;
    sel_t             w_idx;
    logic [N_CH-1:0]  w_onehot;
    logic             w_slot_free;
    logic             w_load;
    logic [N_CH-1:0]  w_gnt;
    logic [WIDTH-1:0] w_word;

    rr_pick4 u_pick (
        .req      (bus.req),
        .last_ptr (r_ptr),
        .any      (w_any),
        .idx      (w_idx),
        .onehot   (w_onehot)
    );

    // In EMPTY the slot is free regardless of out_ready, so gnt has no
    // dependence on out_ready there.
    assign w_slot_free = (r_state == EMPTY) || bus.out_ready;
    assign w_load      = w_slot_free && w_any;
    assign w_gnt       = w_load ? w_onehot : '0;

    always_comb begin
        w_word = '0;
        case (w_idx)
            2'd0:    w_word = bus.a;
            2'd1:    w_word = bus.b;
            2'd2:    w_word = bus.c;
            default: w_word = bus.d;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= PTR_RST;
        end else if (w_load) begin
            r_state <= FULL;
            r_data  <= w_word;
            r_sel   <= w_idx;
            r_ptr   <= w_idx;
        end else if (r_state == FULL && bus.out_ready) begin
            // Drained with nothing to replace it; data and sel keep their value.
            r_state <= EMPTY;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.out_data  = r_data;
    assign bus.sel       = r_sel;
    assign bus.out_valid = (r_state == FULL);

`ifdef MUX4_RR_GNT_CNT_EN
    for (genvar i = 0; i < N_CH; i++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_cnt <= '0;
            end else if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_gnt[i] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign gnt_cnt[i*CNT_W +: CNT_W] = r_cnt;
    end
`endif

endmodule
